// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage decode and pipeline-control bundle for the 5-stage pipeline sequencer.
// master: decode/pipeline side; slave: the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_read_reg0;
    logic [REG_W-1:0] id_read_reg1;
    logic             id_uses_r1;
    logic             id_write;
    logic [REG_W-1:0] id_write_reg;
    logic             id_mem_to_reg;
    logic             id_start;
    logic             ex_branch_taken;

    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_read_reg0, id_read_reg1, id_uses_r1, id_write,
               id_write_reg, id_mem_to_reg, id_start, ex_branch_taken,
        input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
               fwd_a, fwd_b, halted, stall_count
    );

    modport slave (
        input  id_valid, id_read_reg0, id_read_reg1, id_uses_r1, id_write,
               id_write_reg, id_mem_to_reg, id_start, ex_branch_taken,
        output pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
               fwd_a, fwd_b, halted, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the IF/ID/EX/MEM/WB pipeline: destination scoreboard,
// operand forwarding, load-use stall, branch flush and halt drain.
module pipeline_hazard_ctrl #(
    parameter int REG_W     = 4,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             halted_q, halted_d;
    // WB has no consumer (no WB->ID forward path), so only EX and MEM slots are kept.
    logic             ex_valid_q, ex_valid_d;
    logic [REG_W-1:0] ex_dest_q, ex_dest_d;
    logic             ex_load_q, ex_load_d;
    logic             mem_valid_q, mem_valid_d;
    logic [REG_W-1:0] mem_dest_q, mem_dest_d;

    logic             run_s, load_use_s, branch_s, stall_s, halt_s, issue_s;
    logic             pc_write_en_s, ifid_write_en_s, ifid_flush_s, idex_bubble_s;
    logic [1:0]       fwd_a_s, fwd_b_s;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             ex_v,
        input logic             ex_ld,
        input logic [REG_W-1:0] ex_d,
        input logic             mem_v,
        input logic [REG_W-1:0] mem_d
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_v && !ex_ld && (ex_d == src)) begin
            sel = 2'b01;
        end else if (mem_v && (mem_d == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard qualification; a taken branch wins over stall and halt.
    always_comb begin
        run_s      = (state_q == ST_RUN);
        load_use_s = run_s && bus.id_valid && ex_valid_q && ex_load_q &&
                     ((ex_dest_q == bus.id_read_reg0) ||
                      (bus.id_uses_r1 && (ex_dest_q == bus.id_read_reg1)));
        branch_s   = run_s && bus.ex_branch_taken;
        stall_s    = load_use_s && !branch_s;
        halt_s     = run_s && bus.id_valid && bus.id_start && !branch_s && !load_use_s;
        issue_s    = run_s && bus.id_valid && !bus.id_start && !branch_s && !load_use_s;
    end

    // Pipeline controls from current state and ID contents.
    always_comb begin
        pc_write_en_s   = 1'b1;
        ifid_write_en_s = 1'b1;
        ifid_flush_s    = 1'b0;
        idex_bubble_s   = 1'b0;
        fwd_a_s         = 2'b00;
        fwd_b_s         = 2'b00;
        case (state_q)
            ST_RUN: begin
                if (branch_s) begin
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                end else if (stall_s) begin
                    pc_write_en_s   = 1'b0;
                    ifid_write_en_s = 1'b0;
                    idex_bubble_s   = 1'b1;
                end else begin
                    idex_bubble_s = 1'b0;
                end
                if (bus.id_valid) begin
                    fwd_a_s = fwd_sel(bus.id_read_reg0, ex_valid_q, ex_load_q, ex_dest_q,
                                      mem_valid_q, mem_dest_q);
                    if (bus.id_uses_r1) begin
                        fwd_b_s = fwd_sel(bus.id_read_reg1, ex_valid_q, ex_load_q, ex_dest_q,
                                          mem_valid_q, mem_dest_q);
                    end else begin
                        fwd_b_s = 2'b00;
                    end
                end else begin
                    fwd_a_s = 2'b00;
                    fwd_b_s = 2'b00;
                end
            end
            ST_DRAIN, ST_HALTED: begin
                pc_write_en_s   = 1'b0;
                ifid_write_en_s = 1'b0;
                idex_bubble_s   = 1'b1;
            end
            default: begin
                pc_write_en_s   = 1'b0;
                ifid_write_en_s = 1'b0;
                idex_bubble_s   = 1'b1;
            end
        endcase
    end

    // Next-state: scoreboard shift, drain sequencing, stall counter.
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        stall_count_d = stall_count_q;
        ex_valid_d    = issue_s && bus.id_write;
        ex_dest_d     = bus.id_write_reg;
        ex_load_d     = bus.id_mem_to_reg;
        mem_valid_d   = ex_valid_q;
        mem_dest_d    = ex_dest_q;
        case (state_q)
            ST_RUN: begin
                if (halt_s) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = {DW{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q + {{(DW-1){1'b0}}, 1'b1};
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
        if (stall_s && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_d = stall_count_q;
        end
        halted_d = (state_d == ST_HALTED);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            drain_cnt_q   <= {DW{1'b0}};
            stall_count_q <= {CNT_W{1'b0}};
            halted_q      <= 1'b0;
            ex_valid_q    <= 1'b0;
            ex_dest_q     <= {REG_W{1'b0}};
            ex_load_q     <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_dest_q    <= {REG_W{1'b0}};
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            stall_count_q <= stall_count_d;
            halted_q      <= halted_d;
            ex_valid_q    <= ex_valid_d;
            ex_dest_q     <= ex_dest_d;
            ex_load_q     <= ex_load_d;
            mem_valid_q   <= mem_valid_d;
            mem_dest_q    <= mem_dest_d;
        end
    end

    assign bus.pc_write_en   = pc_write_en_s;
    assign bus.ifid_write_en = ifid_write_en_s;
    assign bus.ifid_flush    = ifid_flush_s;
    assign bus.idex_bubble   = idex_bubble_s;
    assign bus.fwd_a         = fwd_a_s;
    assign bus.fwd_b         = fwd_b_s;
    assign bus.halted        = halted_q;
    assign bus.stall_count   = stall_count_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic checked against a queue-based pipeline model.
module tb_pipeline_hazard_ctrl;
    localparam int REG_W     = 4;
    localparam int CNT_W     = 16;
    localparam int DRAIN_CYC = 3;
    localparam logic [24:0] IDLE_RUN = 25'h180_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz_if ();

    pipeline_hazard_ctrl #(.REG_W(REG_W), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hz_if)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [24:0] obs;
    logic [24:0] exp_v;
    assign obs = {hz_if.pc_write_en, hz_if.ifid_write_en, hz_if.ifid_flush, hz_if.idex_bubble,
                  hz_if.fwd_a, hz_if.fwd_b, hz_if.halted, hz_if.stall_count};

    // Model: pipe[0] is the instruction in EX, pipe[1] in MEM, pipe[2] in WB.
    typedef struct { bit valid; int dest; bit load; } slot_t;
    slot_t pipe[$];
    int m_mode;    // 0 run, 1 drain, 2 halted
    int m_drain;
    int m_stalls;

    function automatic bit m_load_use();
        return hz_if.id_valid && pipe[0].valid && pipe[0].load &&
               (pipe[0].dest == int'(hz_if.id_read_reg0) ||
                (hz_if.id_uses_r1 && pipe[0].dest == int'(hz_if.id_read_reg1)));
    endfunction

    function automatic logic [1:0] m_src(input int r);
        if (pipe[0].valid && !pipe[0].load && pipe[0].dest == r) return 2'b01;
        if (pipe[1].valid && pipe[1].dest == r) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [24:0] model_out();
        logic pc, ifid, fl, bub, hl;
        logic [1:0] fa, fb;
        bit br, lu;
        pc = 1'b0; ifid = 1'b0; fl = 1'b0; bub = 1'b1; fa = 2'b00; fb = 2'b00;
        hl = (m_mode == 2);
        if (m_mode == 0) begin
            br = hz_if.ex_branch_taken;
            lu = m_load_use();
            fl = br;
            bub = br || lu;
            pc = br || !lu;
            ifid = br || !lu;
            if (hz_if.id_valid) begin
                fa = m_src(int'(hz_if.id_read_reg0));
                if (hz_if.id_uses_r1) fb = m_src(int'(hz_if.id_read_reg1));
            end
        end
        return {pc, ifid, fl, bub, fa, fb, hl, m_stalls[15:0]};
    endfunction

    task automatic model_step();
        slot_t s;
        bit br, lu;
        s.valid = 1'b0; s.dest = 0; s.load = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_drain = 0; m_stalls = 0;
            pipe = '{s, s, s};
            return;
        end
        if (m_mode == 0) begin
            br = hz_if.ex_branch_taken;
            lu = m_load_use();
            if (lu && !br && m_stalls < 65535) m_stalls++;
            if (hz_if.id_valid && !br && !lu) begin
                if (hz_if.id_start) begin
                    m_mode = 1;
                    m_drain = 0;
                end else if (hz_if.id_write) begin
                    s.valid = 1'b1;
                    s.dest = int'(hz_if.id_write_reg);
                    s.load = hz_if.id_mem_to_reg;
                end
            end
        end else if (m_mode == 1) begin
            m_drain++;
            if (m_drain == DRAIN_CYC) m_mode = 2;
        end
        pipe.push_front(s);
        void'(pipe.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input int r0, input int r1, input bit u1, input bit w,
                         input int wr, input bit ld, input bit st, input bit br);
        hz_if.id_valid        = v;
        hz_if.id_read_reg0    = 4'(r0);
        hz_if.id_read_reg1    = 4'(r1);
        hz_if.id_uses_r1      = u1;
        hz_if.id_write        = w;
        hz_if.id_write_reg    = 4'(wr);
        hz_if.id_mem_to_reg   = ld;
        hz_if.id_start        = st;
        hz_if.ex_branch_taken = br;
    endtask

    task automatic test_reset();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (obs !== IDLE_RUN) begin
            tests_failed++;
            $display("FAIL reset_state: got %h want %h", obs, IDLE_RUN);
        end
        tick();
    endtask

    task automatic test_load_use();
        drive(1'b1, 0, 0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);   // ld r1
        @(negedge clk); exp_v = model_out(); tests_run++;
        if (obs !== exp_v) begin tests_failed++; $display("FAIL lu_load: got %h want %h", obs, exp_v); end
        tick();
        drive(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);   // add r0 = r1 + r2
        @(negedge clk); exp_v = model_out(); tests_run++;
        if (obs !== exp_v || hz_if.pc_write_en !== 1'b0 || hz_if.idex_bubble !== 1'b1) begin
            tests_failed++; $display("FAIL lu_stall: got %h want %h", obs, exp_v);
        end
        tick();
        @(negedge clk); exp_v = model_out(); tests_run++;
        if (obs !== exp_v || hz_if.fwd_a !== 2'b10 || hz_if.pc_write_en !== 1'b1 ||
            hz_if.idex_bubble !== 1'b0) begin
            tests_failed++; $display("FAIL lu_resume: got %h want %h", obs, exp_v);
        end
        tick();
        @(negedge clk); tests_run++;
        if (hz_if.stall_count !== 16'd1) begin
            tests_failed++; $display("FAIL lu_count: got %0d want 1", hz_if.stall_count);
        end
    endtask

    task automatic test_forward();
        drive(1'b1, 3, 3, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0);   // add writes r2
        @(negedge clk); exp_v = model_out(); tests_run++;
        if (obs !== exp_v) begin tests_failed++; $display("FAIL fwd_wr: got %h want %h", obs, exp_v); end
        tick();
        drive(1'b1, 2, 3, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);   // reads r2 right after
        @(negedge clk); exp_v = model_out(); tests_run++;
        if (obs !== exp_v || hz_if.fwd_a !== 2'b01 || hz_if.pc_write_en !== 1'b1) begin
            tests_failed++; $display("FAIL fwd_ex: got %h want %h", obs, exp_v);
        end
        tick();
        drive(1'b1, 2, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);   // reads r2 one instr later
        @(negedge clk); exp_v = model_out(); tests_run++;
        if (obs !== exp_v || hz_if.fwd_a !== 2'b10) begin
            tests_failed++; $display("FAIL fwd_mem: got %h want %h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_priority();
        drive(1'b1, 0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3, 3, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); exp_v = model_out(); tests_run++;
        if (obs !== exp_v || hz_if.fwd_a !== 2'b01 || hz_if.fwd_b !== 2'b00) begin
            tests_failed++; $display("FAIL fwd_prio: got %h want %h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_branch_combo();
        drive(1'b1, 0, 0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);   // ld r1
        tick();
        drive(1'b1, 1, 1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);   // halt reading r1, branch in EX
        @(negedge clk); exp_v = model_out(); tests_run++;
        if (obs !== exp_v || hz_if.ifid_flush !== 1'b1 || hz_if.idex_bubble !== 1'b1 ||
            hz_if.pc_write_en !== 1'b1) begin
            tests_failed++; $display("FAIL br_combo: got %h want %h", obs, exp_v);
        end
        tick();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); exp_v = model_out(); tests_run++;
        if (obs !== exp_v || hz_if.stall_count !== 16'd1 || hz_if.pc_write_en !== 1'b1 ||
            hz_if.halted !== 1'b0) begin
            tests_failed++; $display("FAIL br_after: got %h want %h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_halt();
        drive(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 24; k++) begin
            drive(1'($urandom_range(0, 1)), 1, 1, 1'b1, 1'b1, 1, 1'b0, 1'b0,
                  1'($urandom_range(0, 1)));
            @(negedge clk); exp_v = model_out(); tests_run++;
            if (obs !== exp_v || hz_if.pc_write_en !== 1'b0 || hz_if.ifid_flush !== 1'b0 ||
                hz_if.halted !== (k >= DRAIN_CYC + 1)) begin
                tests_failed++; $display("FAIL halt_k%0d: got %h want %h", k, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_reset_in_drain();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk); tests_run++;
        if (obs !== IDLE_RUN) begin
            tests_failed++; $display("FAIL rst_drain: got %h want %h", obs, IDLE_RUN);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) < ((m_mode == 2) ? 25 : 1)) ? 1'b0 : 1'b1;
            drive(($urandom_range(0, 99) < 85), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 70), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 99) < 10));
            @(negedge clk); exp_v = model_out(); tests_run++;
            if (obs !== exp_v) begin
                tests_failed++; $display("FAIL random_%0d: got %h want %h", n, obs, exp_v);
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_priority();
        test_branch_combo();
        test_halt();
        test_reset_in_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
